// File: rtl/shared_mux_arbiter_if.sv
// Bundles the requester-side and output-side handshake of the shared output channel.
// The arbiter uses the slave view; whatever drives the requesters and sinks the output uses the master view.
interface shared_mux_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/shared_mux_arbiter.sv
// Round-robin arbiter that multiplexes N valid/ready requesters into a single
// registered output stage with one-cycle latency and full throughput.
module shared_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  shared_mux_arbiter_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [SW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_src_q, out_src_d;

  logic          loadable;
  logic          grant_found;
  logic [SW-1:0] grant_idx;
  logic [SW:0]   scan_idx;
  logic [N-1:0]  grant_oh;
  logic          take;

  // The stage can accept a new beat when it is empty or is being drained this cycle.
  assign loadable = !out_valid_q || bus.out_ready;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = {1'b0, ptr_q} + (SW+1)'(i);
      if (scan_idx >= (SW+1)'(N)) begin
        scan_idx = scan_idx - (SW+1)'(N);
      end
      if (!grant_found && bus.req_valid[scan_idx[SW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[SW-1:0];
      end
    end
  end

  assign take = loadable && grant_found;

  always_comb begin
    grant_oh = '0;
    if (take) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (take) begin
      // A new beat overwrites the held one when both transfers coincide.
      out_valid_d = 1'b1;
      out_data_d  = bus.req_data[grant_idx*W +: W];
      out_src_d   = grant_idx;
      ptr_d       = (grant_idx == SW'(N-1)) ? '0 : grant_idx + 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.req_ready & ~bus.req_valid) == '0);

  a_stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_src_q) && $stable(ptr_q)));
endmodule

// File: tb/tb_shared_mux_arbiter.sv
// Directed and randomized checks of shared_mux_arbiter: expected beats are queued
// when a grant is predicted and a separate monitor compares them as they leave.
module tb_shared_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] data;
    int           src;
  } beat_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  beat_t sb[$];
  int    m_ptr;
  logic  m_ov;
  int    wait_cnt[N];

  shared_mux_arbiter_if #(.N(N), .W(W)) bus ();

  shared_mux_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference prediction for the current cycle, evaluated at the falling edge.
  task automatic step();
    int           win;
    logic         load;
    logic         starved;
    logic [N-1:0] exp_rdy;
    load = !m_ov || bus.out_ready;
    win  = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (win < 0 && bus.req_valid[k]) win = k;
    end
    exp_rdy = '0;
    if (load && win >= 0) exp_rdy[win] = 1'b1;
    check("req_ready_model", 32'(bus.req_ready), 32'(exp_rdy));
    check("out_valid_model", 32'(bus.out_valid), 32'(m_ov));
    if (exp_rdy != '0) begin
      sb.push_back('{data: bus.req_data[win*W +: W], src: win});
      starved = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (k == win)               wait_cnt[k] = 0;
        else if (bus.req_valid[k])  wait_cnt[k] = wait_cnt[k] + 1;
        else                        wait_cnt[k] = 0;
        if (wait_cnt[k] >= N) starved = 1'b1;
      end
      check("starvation", 32'(starved), 32'd0);
      m_ptr = (win + 1) % N;
      m_ov  = 1'b1;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic ordy, input int hand_rdy);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.out_ready = ordy;
    @(negedge clk);
    if (hand_rdy >= 0) check("req_ready_hand", 32'(bus.req_ready), 32'(hand_rdy[N-1:0]));
    step();
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr = 0;
    m_ov  = 1'b0;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
  endtask

  // Output monitor: pops one expected beat per output-side transfer.
  initial begin
    beat_t exp_b;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          exp_b = sb.pop_front();
          check("out_data", 32'(bus.out_data), 32'(exp_b.data));
          check("out_src",  32'(bus.out_src),  32'(exp_b.src));
        end
      end
    end
  end

  initial begin
    logic [N*W-1:0] std_data;
    logic [N*W-1:0] d55;
    logic [N*W-1:0] rnd_data;
    logic [N-1:0]   rnd_v;
    logic           rnd_r;
    total = 0;
    bad   = 0;
    std_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    d55      = {8'hEE, 8'h55, 8'hDD, 8'hCC};
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    model_reset();

    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_src",   32'(bus.out_src),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle: nothing requested, output stays empty.
    for (int c = 0; c < 5; c++) begin
      cycle(4'b0000, std_data, 1'b1, 0);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_out_data",  32'(bus.out_data),  32'd0);
    end

    // All requesters busy: grants rotate 0,1,2,3 at one per cycle.
    for (int c = 0; c < 8; c++) begin
      cycle(4'b1111, std_data, 1'b1, 1 << (c % 4));
      if (c > 0) begin
        check("rr_out_src",  32'(bus.out_src),  32'((c - 1) % 4));
        check("rr_out_data", 32'(bus.out_data), 32'(8'hA0 + (c - 1) % 4));
      end
    end
    cycle(4'b0000, std_data, 1'b1, 0);

    // Single requester 2 with a stalled output.
    cycle(4'b0100, d55, 1'b0, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0100, d55, 1'b0, 0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_out_data",  32'(bus.out_data),  32'h55);
      check("stall_out_src",   32'(bus.out_src),   32'd2);
    end
    cycle(4'b0100, d55, 1'b1, 4'b0100);

    // Pointer at 3: requesters 3 and 0 alternate across the wrap.
    cycle(4'b1001, std_data, 1'b1, 4'b1000);
    cycle(4'b1001, std_data, 1'b1, 4'b0001);
    cycle(4'b1001, std_data, 1'b1, 4'b1000);
    cycle(4'b0000, std_data, 1'b1, 0);
    cycle(4'b0000, std_data, 1'b1, 0);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_out_data",  32'(bus.out_data),  32'hA3);
    check("drain_out_src",   32'(bus.out_src),   32'd3);

    // Reset while a beat is held: the beat is discarded and the pointer restarts at 0.
    cycle(4'b0100, std_data, 1'b0, 4'b0100);
    cycle(4'b0000, std_data, 1'b0, 0);
    check("held_before_rst", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_data",  32'(bus.out_data),  32'd0);
    check("async_rst_src",   32'(bus.out_src),   32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(4'b1001, std_data, 1'b1, 4'b0001);
    cycle(4'b0000, std_data, 1'b1, 0);
    check("post_rst_src", 32'(bus.out_src), 32'd0);

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 10000; c++) begin
      rnd_v    = N'($urandom_range(0, (1 << N) - 1));
      rnd_r    = ($urandom_range(0, 3) != 0);
      rnd_data = {$urandom, $urandom};
      cycle(rnd_v, rnd_data, rnd_r, -1);
    end

    cycle(4'b0000, std_data, 1'b1, 0);
    cycle(4'b0000, std_data, 1'b1, 0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
